// File: rtl/mdu_sched.sv
// Multiply/divide sequencer: captures one MDU op, launches the shared unit, holds the pipe until the result is consumed.
// Optional MDU_PAIR_REUSE_EN: reuse the last divider result for a matching div/mod pair.
module mdu_sched #(
    parameter int W   = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    input  logic [OPW-1:0] req_op,
    input  logic           req_sign,
    input  logic [W-1:0]   req_src1,
    input  logic [W-1:0]   req_src2,
    input  logic           kill,
    input  logic           hold,
    output logic           req_ready,
    output logic           res_valid,
    output logic [W-1:0]   res_data,
    output logic           busy,
    output logic           mul_start,
    output logic           mul_flush,
    input  logic           mul_done,
    input  logic [W-1:0]   mul_hi,
    input  logic [W-1:0]   mul_lo,
    output logic           div_start,
    output logic           div_flush,
    input  logic           div_done,
    input  logic [W-1:0]   div_q,
    input  logic [W-1:0]   div_r,
    output logic           op_sign,
    output logic [W-1:0]   op_a,
    output logic [W-1:0]   op_b
);

    typedef enum logic [1:0] {IDLE, MWAIT, DWAIT, DONE} state_t;

    state_t         state, state_nx;
    logic [OPW-1:0] op_q, op_sel;
    logic           sign_q;
    logic [W-1:0]   a_q, b_q, res_q, res_nx, reuse_res;
    logic           accept, sel_mul, reuse_hit, res_load;

    // lowest set bit of a multi-hot op wins
    assign op_sel  = req_op & (~req_op + OPW'(1));
    assign sel_mul = op_sel[0] | op_sel[2];
    assign accept  = (state == IDLE) && req_valid && (req_op != '0) && !kill && !reset;

    // units sample operands on the start pulse, so forward them in the launch cycle
    assign op_sign  = accept ? req_sign : sign_q;
    assign op_a     = accept ? req_src1 : a_q;
    assign op_b     = accept ? req_src2 : b_q;
    assign res_data = res_q;

`ifdef MDU_PAIR_REUSE_EN
    logic         reuse_vld, rs_sign;
    logic [W-1:0] rs_a, rs_b, rs_q, rs_r;

    assign reuse_hit = reuse_vld && !sel_mul && (req_sign == rs_sign) &&
                       (req_src1 == rs_a) && (req_src2 == rs_b);
    assign reuse_res = op_sel[1] ? rs_r : rs_q;

    always_ff @(posedge clk) begin
        if (reset || kill) begin
            reuse_vld <= 1'b0;
            rs_sign   <= 1'b0;
            rs_a      <= '0;
            rs_b      <= '0;
            rs_q      <= '0;
            rs_r      <= '0;
        end else if (accept && sel_mul) begin
            reuse_vld <= 1'b0;
        end else if (state == DWAIT && div_done) begin
            reuse_vld <= 1'b1;
            rs_sign   <= sign_q;
            rs_a      <= a_q;
            rs_b      <= b_q;
            rs_q      <= div_q;
            rs_r      <= div_r;
        end
    end
`else
    assign reuse_hit = 1'b0;
    assign reuse_res = '0;
`endif

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        res_valid = 1'b0;
        busy      = (state != IDLE);
        mul_start = 1'b0;
        div_start = 1'b0;
        mul_flush = kill;
        div_flush = kill;
        res_load  = 1'b0;
        res_nx    = res_q;
        case (state)
            IDLE: begin
                req_ready = !accept;
                if (accept) begin
                    if (sel_mul) begin
                        mul_start = 1'b1;
                        state_nx  = MWAIT;
                    end else if (reuse_hit) begin
                        res_load = 1'b1;
                        res_nx   = reuse_res;
                        state_nx = DONE;
                    end else begin
                        div_start = 1'b1;
                        state_nx  = DWAIT;
                    end
                end
            end
            MWAIT: if (mul_done) begin
                res_load = 1'b1;
                res_nx   = op_q[2] ? mul_hi : mul_lo;
                state_nx = DONE;
            end
            DWAIT: if (div_done) begin
                res_load = 1'b1;
                res_nx   = op_q[1] ? div_r : div_q;
                state_nx = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                req_ready = !hold;
                if (!hold) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (kill) begin
            state_nx = IDLE;
            res_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= '0;
            sign_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q   <= op_sel;
                sign_q <= req_sign;
                a_q    <= req_src1;
                b_q    <= req_src2;
            end
            if (res_load) res_q <= res_nx;
        end
    end

endmodule

// File: tb/tb_mdu_sched.sv
// Randomized self-checking bench for mdu_sched with behavioural mul/div unit models.
module tb_mdu_sched;

    logic        clk = 1'b0;
    logic        reset, req_valid, req_sign, kill, hold;
    logic [3:0]  req_op;
    logic [31:0] req_src1, req_src2;
    logic        req_ready, res_valid, busy, mul_start, mul_flush, div_start, div_flush;
    logic [31:0] res_data, op_a, op_b;
    logic        op_sign;
    logic        mul_done, div_done;
    logic [31:0] mul_hi, mul_lo, div_q, div_r;

    int n_vec = 0;
    int n_err = 0;

    // reference view of the divider-result reuse buffer
    bit          rv = 1'b0;
    bit          sv_sign;
    logic [31:0] sv_a, sv_b;

    mdu_sched #(.W(32), .OPW(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_sign(req_sign), .req_src1(req_src1), .req_src2(req_src2),
        .kill(kill), .hold(hold), .req_ready(req_ready), .res_valid(res_valid),
        .res_data(res_data), .busy(busy), .mul_start(mul_start), .mul_flush(mul_flush),
        .mul_done(mul_done), .mul_hi(mul_hi), .mul_lo(mul_lo), .div_start(div_start),
        .div_flush(div_flush), .div_done(div_done), .div_q(div_q), .div_r(div_r),
        .op_sign(op_sign), .op_a(op_a), .op_b(op_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mul_model(input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        ea = s ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    // returns {quotient, remainder}
    function automatic logic [63:0] div_model(input bit s, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 32'h0) return {32'hFFFFFFFF, a};
        if (s) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {a, 32'h0};
            sa = a;
            sb = b;
            return {32'(sa / sb), 32'(sa % sb)};
        end
        return {a / b, a % b};
    endfunction

    task automatic idle_check(input string tag, input logic [31:0] exp_res);
        req_valid = 1'b0; req_op = 4'h0; kill = 1'b0; hold = 1'b0;
        mul_done = 1'b0; div_done = 1'b0;
        #1;
        check({tag, "_busy"}, busy, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_res_data"}, res_data, exp_res);
        @(negedge clk);
    endtask

    // kill_at: -1 none, 0 in the request cycle, c>0 in wait cycle c (c==lat coincides with done)
    task automatic do_op(input logic [3:0] op, input bit s, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int holdn, input int kill_at, input logic [31:0] prev_res);
        logic [3:0]  sel;
        logic [63:0] m, d;
        logic [31:0] exp;
        bit          is_mul, reuse, k;
        sel    = op & (~op + 4'd1);
        is_mul = sel[0] | sel[2];
        m      = mul_model(s, a, b);
        d      = div_model(s, a, b);
        exp    = sel[0] ? m[31:0] : sel[2] ? m[63:32] : sel[3] ? d[63:32] : d[31:0];
        reuse  = 1'b0;
`ifdef MDU_PAIR_REUSE_EN
        reuse = !is_mul && rv && sv_sign == s && sv_a == a && sv_b == b;
`endif
        k = (kill_at == 0);
        req_valid = 1'b1; req_op = op; req_sign = s; req_src1 = a; req_src2 = b; kill = k;
        mul_hi = m[63:32]; mul_lo = m[31:0]; div_q = d[63:32]; div_r = d[31:0];
        #1;
        check("req_ready_req", req_ready, k);
        check("mul_start", mul_start, is_mul && !k);
        check("div_start", div_start, !is_mul && !reuse && !k);
        check("flush_req", {mul_flush, div_flush}, {k, k});
        if (k) begin
            rv = 1'b0;
            @(negedge clk);
            idle_check("kill_req", prev_res);
            return;
        end
        check("op_a", op_a, a);
        check("op_b", op_b, b);
        check("op_sign", op_sign, s);
        if (is_mul) rv = 1'b0;
        @(negedge clk);
        if (!reuse) begin
            for (int c = 1; c <= lat; c++) begin
                k = (c == kill_at);
                req_valid = 1'($urandom); req_op = 4'($urandom); req_sign = 1'($urandom);
                req_src1 = $urandom; req_src2 = $urandom; kill = k;
                mul_done = is_mul ? (c == lat) : 1'($urandom);
                div_done = is_mul ? 1'($urandom) : (c == lat);
                #1;
                check("wait_req_ready", req_ready, 0);
                check("wait_busy", busy, 1);
                check("wait_res_valid", res_valid, 0);
                check("wait_starts", {mul_start, div_start}, 0);
                if (k) begin
                    check("wait_flush", {mul_flush, div_flush}, 2'b11);
                    rv = 1'b0;
                    @(negedge clk);
                    idle_check("kill_wait", prev_res);
                    return;
                end
                @(negedge clk);
            end
            mul_done = 1'b0; div_done = 1'b0;
            if (!is_mul) begin
                rv = 1'b1; sv_sign = s; sv_a = a; sv_b = b;
            end
        end
        for (int h = 0; h <= holdn; h++) begin
            hold = (h < holdn); kill = 1'b0;
            req_valid = 1'($urandom); req_op = 4'($urandom); req_src1 = $urandom;
            #1;
            check("done_res_valid", res_valid, 1);
            check("done_res_data", res_data, exp);
            check("done_req_ready", req_ready, !hold);
            check("done_starts", {mul_start, div_start}, 0);
            @(negedge clk);
        end
        idle_check("after_done", exp);
    endtask

    initial begin
        logic [31:0] last, a, b;
        logic [3:0]  op;
        bit          s;
        int          lat, kat;
        reset = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_sign = 1'b0;
        req_src1 = '0; req_src2 = '0; kill = 1'b0; hold = 1'b0;
        mul_done = 1'b0; div_done = 1'b0; mul_hi = '0; mul_lo = '0; div_q = '0; div_r = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_req_ready", req_ready, 1);
        check("reset_starts", {mul_start, div_start}, 0);
        @(negedge clk);
        reset = 1'b0;
        idle_check("post_reset", 32'h0);
        check("post_reset_op_a", op_a, 0);

        // non-MDU instructions stream through
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_op = 4'h0; req_src1 = $urandom; req_src2 = $urandom;
            #1;
            check("stream_ready", req_ready, 1);
            check("stream_starts", {mul_start, div_start}, 0);
            check("stream_busy", busy, 0);
            @(negedge clk);
        end

        do_op(4'b0001, 1'b1, 32'hFFFFFFFD, 32'd7, 3, 0, -1, 32'h0);
        do_op(4'b1000, 1'b1, 32'd7, 32'hFFFFFFFE, 4, 0, -1, 32'hFFFFFFEB);
        do_op(4'b0010, 1'b1, 32'd7, 32'hFFFFFFFE, 3, 0, -1, 32'hFFFFFFFD);
        do_op(4'b1000, 1'b0, 32'd100, 32'd9, 3, 0, 1, 32'h1);
        do_op(4'b1000, 1'b0, 32'd101, 32'd9, 2, 0, 2, 32'h1);
        do_op(4'b0100, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 5, -1, 32'h1);
        do_op(4'b1000, 1'b0, 32'd55, 32'd0, 1, 0, -1, 32'hFFFFFFFE);
        last = res_data;

        // reset while the multiplier is busy
        req_valid = 1'b1; req_op = 4'b0001; req_src1 = 32'd3; req_src2 = 32'd4;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; rv = 1'b0;
        idle_check("reset_mwait", 32'h0);
        check("reset_mwait_op_a", op_a, 0);
        last = 32'h0;

        for (int i = 0; i < 80; i++) begin
            op  = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 2) != 0 || i == 0) begin
                s = 1'($urandom);
                a = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) - 32'd20 : $urandom;
                b = ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom_range(0, 12)) - 32'd6;
            end
            lat = $urandom_range(1, 4);
            kat = ($urandom_range(0, 7) == 0) ? $urandom_range(0, lat) : -1;
            do_op(op, s, a, b, lat, $urandom_range(0, 3), kat, last);
            last = res_data;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
